// File: rtl/result_accumulator_pkg.sv
// result_accumulator_pkg: shared state encoding, default widths and the sum extension helper
package result_accumulator_pkg;
    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
    localparam int DEF_WIDTH = 16;
    localparam int DEF_COUNT_W = 4;
    localparam int DEF_ACC_W = 20;
    // extends the low w bits of v to 64 bits, sign-extending when s is set
    function automatic logic [63:0] ext(input logic [63:0] v, input int w, input logic s);
        logic [63:0] m;
        m = ~64'd0 << w;
        return (s && v[w-1]) ? (v | m) : (v & ~m);
    endfunction
endpackage

// File: rtl/result_accumulator.sv
// result_accumulator: sums a programmable-length block of adder results and offers it via valid/ready
// ports: clk, rst (sync, active-low) | sum_in, sum_valid, in_ready, signed_mode, len (sample side)
//        acc_out, out_valid, out_ready (result side) | busy, drop (status)
module result_accumulator
    import result_accumulator_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int COUNT_W = DEF_COUNT_W,
    parameter int ACC_W   = DEF_ACC_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   sum_in,
    input  logic               sum_valid,
    output logic               in_ready,
    input  logic               signed_mode,
    input  logic [COUNT_W-1:0] len,
    output logic [ACC_W-1:0]   acc_out,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy,
    output logic               drop
);
    state_t             state;
    logic [COUNT_W-1:0] len_q;
    logic [COUNT_W:0]   cnt;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   x;
    logic [ACC_W-1:0]   acc_n;
    logic [COUNT_W:0]   cnt_n;
    logic [COUNT_W:0]   eff_in;
    logic [COUNT_W:0]   eff_q;
    assign in_ready = state != HOLD;
    assign x        = ACC_W'(ext(64'(sum_in), WIDTH, signed_mode));
    assign acc_n    = acc + x;
    assign cnt_n    = cnt + 1'b1;
    // a zero length field stands for the full 2^COUNT_W block
    assign eff_in   = (len == '0) ? {1'b1, {COUNT_W{1'b0}}} : {1'b0, len};
    assign eff_q    = (len_q == '0) ? {1'b1, {COUNT_W{1'b0}}} : {1'b0, len_q};
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            len_q     <= '0;
            cnt       <= '0;
            acc       <= '0;
            acc_out   <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            drop      <= 1'b0;
        end else begin
            if (sum_valid && !in_ready) drop <= 1'b1;
            case (state)
                IDLE: if (sum_valid) begin
                    len_q <= len;
                    acc   <= x;
                    cnt   <= {{COUNT_W{1'b0}}, 1'b1};
                    busy  <= 1'b1;
                    if (eff_in == {{COUNT_W{1'b0}}, 1'b1}) begin
                        acc_out   <= x;
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end else begin
                        state <= ACCUM;
                    end
                end
                ACCUM: if (sum_valid) begin
                    acc <= acc_n;
                    cnt <= cnt_n;
                    if (cnt_n == eff_q) begin
                        acc_out   <= acc_n;
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end
                end
                HOLD: if (out_ready) begin
                    acc       <= '0;
                    cnt       <= '0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/result_accumulator.md
# result_accumulator

Downstream stage of the 16-bit add/subtract unit: consumes each registered sum the adder produces and accumulates a programmable-length block of sums into a wider result. A completed result is offered through a valid/ready handshake to the next consumer. Typical uses are block sums and running differences for the lab datapath. Sums are sign- or zero-extended before accumulation, and the width rule guarantees the accumulator never overflows.

## Interface
Parameters:
- WIDTH, 16, width of incoming sum
- COUNT_W, 4, width of block-length field; max block = 2^COUNT_W samples
- ACC_W, 20, accumulator/result width; must be ≥ WIDTH+COUNT_W

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-low
- sum_in  in  WIDTH  registered sum from adder stage
- sum_valid  in  1  sum_in holds a new sample this cycle
- in_ready  out  1  block can take a sample this cycle
- signed_mode  in  1  1 = sign-extend sum_in, 0 = zero-extend; sampled per sample
- len  in  COUNT_W  samples per block; 0 encodes 2^COUNT_W; captured on first sample of a block
- acc_out  out  ACC_W  completed block result
- out_valid  out  1  acc_out holds an unconsumed result
- out_ready  in  1  consumer accepts acc_out
- busy  out  1  block in progress (ACCUM or HOLD)
- drop  out  1  sticky: a sample arrived while in_ready was low

## Operation
- States: IDLE, ACCUM, HOLD.
- Sample accepted when sum_valid && in_ready. in_ready = (state != HOLD), a decode of the state register only.
- IDLE: on accept, capture len into len_q; acc ← ext(sum_in); cnt ← 1. If the effective length (len, with 0 mapping to 2^COUNT_W) is 1, load acc_out ← ext(sum_in) and go to HOLD. Otherwise go to ACCUM.
- ACCUM: on accept, acc ← acc + ext(sum_in); cnt ← cnt+1. When cnt+1 equals the effective length, load acc_out with the new sum and go to HOLD. Cycles with no sum_valid leave everything unchanged.
- HOLD: out_valid=1, acc_out stable. On out_ready, go to IDLE and clear acc and cnt.
- Any sum_valid while in HOLD is discarded and sets drop. drop clears only on reset.
- ext(): sign- or zero-extend to ACC_W according to signed_mode. Addition is ACC_W-bit two's complement.
- Overflow: none is possible. In the worst case, 16 × 65535 < 2^20 unsigned, and 16 × (−32768) = −2^19 signed.
- cnt is COUNT_W+1 bits so that 2^COUNT_W is representable.
- len changes mid-block are ignored; len_q governs the block.
- Reset (rst=0 at a clk edge, in any state, including mid-block or HOLD):
  - state IDLE, acc 0, cnt 0, acc_out 0, out_valid 0, busy 0, drop 0; in_ready reads 1.
  - A partial block or pending result is lost.

## Timing
- Sample accepted at edge t. If it is the last sample of the block, out_valid=1 and acc_out is valid after edge t (latency 1).
- Handshake completes at the edge with out_valid && out_ready. out_valid is 0 after that edge, and in_ready is 1 the same cycle.
- A sample presented in that same handshake cycle is dropped, because in_ready is still low.
- acc_out holds its value after the handshake until the next block completes.
- The adder stage asserts sum_valid one cycle after its en (register update). Back-to-back samples every cycle are sustained in ACCUM.

## Structure
- Shared package: state enum (IDLE/ACCUM/HOLD), default WIDTH/COUNT_W/ACC_W constants, and an ext() sign/zero-extend function.
- Single module, with no sub-modules; the counter and accumulator are inline.

## Test plan
- Unsigned block: signed_mode=0, len=4, samples 1,2,3,4 on consecutive cycles → out_valid 1 cycle after the 4th, acc_out=10; out_ready=1 → IDLE.
- Signed wrap: signed_mode=1, len=0 (16 samples), all 0x8000 → acc_out=0x80000 (−524288); then all 0xFFFF unsigned → 0xFFFF0 (1048560).
- Backpressure/drop: complete a len=2 block, hold out_ready=0 for 5 cycles, and pulse sum_valid twice → acc_out stable, in_ready=0, drop=1; the next block is unaffected.
- len=1 with a gapped stream: len=1, samples 7 and 9 spaced by idle cycles with out_ready=1 → two results 7 and 9; gaps do not disturb cnt.
- Mid-block reset: len=8, 3 samples, then rst=0 for 1 cycle → all outputs 0; a new len=2 block with 5,6 → acc_out=11.
- Mid-block len change: len=3 captured at start, len driven to 1 after the first sample → result after 3 samples.
